// File: rtl/gci_std_kmc_ps2_keyevent_ctrl.sv
// rtl/gci_std_kmc_ps2_keyevent_ctrl.sv - PS/2 set-2 prefix parser feeding a FWFT key-event FIFO
module gci_std_kmc_ps2_keyevent_ctrl #(
    parameter int P_FIFO_DEPTH_N = 4,
    parameter int P_TIMEOUT      = 1000000
) (
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iRESET_SYNC,
    input  logic                      iPS2MOD_REQ,
    input  logic [7:0]                iPS2MOD_DATA,
    input  logic                      iEVENT_RD_REQ,
    output logic                      oEVENT_VALID,
    output logic [9:0]                oEVENT_DATA,
    output logic [P_FIFO_DEPTH_N:0]   oEVENT_COUNT,
    output logic                      oOVERFLOW,
    output logic                      oERROR
);
    localparam int TW = $clog2(P_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT - 1);
    localparam logic [P_FIFO_DEPTH_N:0] DEPTH_C = {1'b1, {P_FIFO_DEPTH_N{1'b0}}};

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                skip_q, skip_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      err_q, ovf_q;
    logic [P_FIFO_DEPTH_N-1:0] wptr_q, rptr_q;
    logic [P_FIFO_DEPTH_N:0]   count_q;
    logic [9:0]                mem_q [2**P_FIFO_DEPTH_N];

    logic       push, err_set, bad_byte;
    logic [9:0] evt;
    logic       pop, full, do_wr, ovf_set;

    assign bad_byte = (iPS2MOD_DATA == 8'h00) || (iPS2MOD_DATA == 8'hFF);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        push    = 1'b0;
        evt     = '0;
        err_set = 1'b0;
        if (iPS2MOD_REQ) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (iPS2MOD_DATA == 8'hE0) state_d = EXT;
                    else if (iPS2MOD_DATA == 8'hF0) state_d = BRK;
                    else if (iPS2MOD_DATA == 8'hE1) begin
                        state_d = PAUSE;
                        skip_d  = 3'd7;
                    end else if (bad_byte) err_set = 1'b1;
                    else begin
                        push = 1'b1;
                        evt  = {2'b00, iPS2MOD_DATA};
                    end
                end
                EXT: begin
                    if (iPS2MOD_DATA == 8'hF0) state_d = EXT_BRK;
                    else if (iPS2MOD_DATA == 8'hE0) state_d = EXT;
                    else begin
                        state_d = IDLE;
                        err_set = bad_byte;
                        push    = !bad_byte;
                        evt     = {2'b01, iPS2MOD_DATA};
                    end
                end
                BRK, EXT_BRK: begin
                    state_d = IDLE;
                    err_set = bad_byte;
                    push    = !bad_byte;
                    evt     = {1'b1, state_q == EXT_BRK, iPS2MOD_DATA};
                end
                PAUSE: begin
                    // Pause bytes carry no key information; only their count matters.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = IDLE;
                        push    = 1'b1;
                        evt     = 10'h1E1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_set = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign full    = (count_q == DEPTH_C);
    assign pop     = iEVENT_RD_REQ && (count_q != '0);
    assign do_wr   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (iRESET_SYNC) begin
            state_q <= IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            err_q   <= err_q | err_set;
            ovf_q   <= ovf_q | ovf_set;
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
            if (do_wr && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !do_wr) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (do_wr && !iRESET_SYNC) mem_q[wptr_q] <= evt;
    end

    assign oEVENT_VALID = (count_q != '0);
    assign oEVENT_DATA  = oEVENT_VALID ? mem_q[rptr_q] : '0;
    assign oEVENT_COUNT = count_q;
    assign oOVERFLOW    = ovf_q;
    assign oERROR       = err_q;
endmodule

// File: tb/tb_gci_std_kmc_ps2_keyevent_ctrl.sv
// tb/tb_gci_std_kmc_ps2_keyevent_ctrl.sv - randomized and directed check of the key-event controller
module tb_gci_std_kmc_ps2_keyevent_ctrl;
    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rst_sync;
    logic       ps2_req;
    logic [7:0] ps2_data;
    logic       rd_req;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic [N:0] ev_count;
    logic       ovf, err;

    always #5 clk = ~clk;

    gci_std_kmc_ps2_keyevent_ctrl #(.P_FIFO_DEPTH_N(N), .P_TIMEOUT(TMO)) dut (
        .iCLOCK(clk), .inRESET(nrst), .iRESET_SYNC(rst_sync),
        .iPS2MOD_REQ(ps2_req), .iPS2MOD_DATA(ps2_data), .iEVENT_RD_REQ(rd_req),
        .oEVENT_VALID(ev_valid), .oEVENT_DATA(ev_data), .oEVENT_COUNT(ev_count),
        .oOVERFLOW(ovf), .oERROR(err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    string phase = "reset";

    logic [9:0]   mq[$];
    byte unsigned pend[$];
    bit           m_err, m_ovf;
    int           idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        mq.delete();
        pend.delete();
        m_err = 0;
        m_ovf = 0;
        idle  = 0;
    endtask

    // Pending prefix bytes are kept as a list; an event is decided once a code byte completes it.
    task automatic model_edge(input bit req, input byte unsigned b, input bit rd, input bit srst);
        bit         has_ev = 0;
        bit         drop;
        bit         pop_ok;
        bit         ext = 0;
        bit         brk = 0;
        logic [9:0] ev = '0;
        if (srst) begin
            model_clear();
            return;
        end
        if (req) begin
            idle = 0;
            foreach (pend[i]) begin
                if (pend[i] == 8'hE0) ext = 1;
                if (pend[i] == 8'hF0) brk = 1;
            end
            if (pend.size() > 0 && pend[0] == 8'hE1) begin
                pend.push_back(b);
                if (pend.size() == 8) begin
                    has_ev = 1;
                    ev = 10'h1E1;
                    pend.delete();
                end
            end else if (b == 8'h00 || b == 8'hFF) begin
                m_err = 1;
                pend.delete();
            end else if (!brk && b == 8'hF0) begin
                pend.push_back(b);
            end else if (pend.size() == 0 && b == 8'hE1) begin
                pend.push_back(b);
            end else if (!brk && b == 8'hE0) begin
                if (pend.size() == 0) pend.push_back(b);
            end else begin
                has_ev = 1;
                ev = {brk, ext, b};
                pend.delete();
            end
        end else if (pend.size() > 0) begin
            idle++;
            if (idle == TMO) begin
                m_err = 1;
                pend.delete();
                idle = 0;
            end
        end else begin
            idle = 0;
        end
        pop_ok = rd && mq.size() > 0;
        drop   = has_ev && mq.size() == DEPTH && !pop_ok;
        if (drop) m_ovf = 1;
        if (pop_ok) void'(mq.pop_front());
        if (has_ev && !drop) mq.push_back(ev);
    endtask

    task automatic check_all();
        check({phase, ":valid"}, 32'(ev_valid), 32'(mq.size() > 0));
        check({phase, ":data"}, 32'(ev_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        check({phase, ":count"}, 32'(ev_count), 32'(mq.size()));
        check({phase, ":overflow"}, 32'(ovf), 32'(m_ovf));
        check({phase, ":error"}, 32'(err), 32'(m_err));
    endtask

    task automatic cyc(input bit req, input byte unsigned d, input bit rd, input bit srst);
        ps2_req  = req;
        ps2_data = d;
        rd_req   = rd;
        rst_sync = srst;
        @(posedge clk);
        model_edge(req, d, rd, srst);
        #1;
        check_all();
        ps2_req  = 0;
        ps2_data = 8'h00;
        rd_req   = 0;
        rst_sync = 0;
    endtask

    task automatic send(input byte unsigned b);
        cyc(1, b, 0, 0);
    endtask

    task automatic pop();
        cyc(0, 8'h00, 1, 0);
    endtask

    task automatic wait_idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
    endtask

    task automatic sclear();
        cyc(0, 8'h00, 0, 1);
    endtask

    initial begin
        byte unsigned b;
        int           rd_pct;
        nrst = 0; rst_sync = 0; ps2_req = 0; ps2_data = 0; rd_req = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        nrst = 1;

        phase = "make_break";
        send(8'h1C);
        check("mb:first", 32'(ev_data), 32'h01C);
        check("mb:cnt1", 32'(ev_count), 32'd1);
        send(8'hF0); send(8'h1C);
        check("mb:cnt2", 32'(ev_count), 32'd2);
        pop();
        check("mb:second", 32'(ev_data), 32'h21C);
        pop();
        check("mb:empty_data", 32'(ev_data), 32'd0);

        phase = "extended";
        send(8'hE0); send(8'hF0);
        check("ext:no_prefix_evt", 32'(ev_count), 32'd0);
        send(8'h75);
        check("ext:brk", 32'(ev_data), 32'h375);
        send(8'hE0); send(8'h75); pop();
        check("ext:make", 32'(ev_data), 32'h175);
        pop();

        phase = "pause";
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause:one", 32'(ev_count), 32'd1);
        check("pause:evt", 32'(ev_data), 32'h1E1);
        send(8'h1C); pop();
        check("pause:after", 32'(ev_data), 32'h01C);
        pop();

        phase = "overflow";
        for (int i = 1; i <= 17; i++) send(byte'(i));
        check("ovf:count", 32'(ev_count), 32'd16);
        check("ovf:flag", 32'(ovf), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            check("ovf:order", 32'(ev_data), 32'(i));
            pop();
        end
        sclear();
        for (int i = 0; i < 16; i++) send(byte'(8'h20 + i));
        cyc(1, 8'h40, 1, 0);
        check("full_pp:count", 32'(ev_count), 32'd16);
        check("full_pp:ovf", 32'(ovf), 32'd0);
        check("full_pp:head", 32'(ev_data), 32'h021);

        phase = "timeout";
        sclear();
        send(8'hE0); wait_idle(TMO); send(8'h1C);
        check("tmo:err", 32'(err), 32'd1);
        check("tmo:evt", 32'(ev_data), 32'h01C);
        sclear();
        send(8'hE0); wait_idle(TMO - 2); send(8'h1C);
        check("tmo_ok:evt", 32'(ev_data), 32'h11C);
        check("tmo_ok:err", 32'(err), 32'd0);

        phase = "line_err";
        sclear();
        send(8'hFF);
        check("lerr:idle", 32'(err), 32'd1);
        send(8'hF0); send(8'h00);
        check("lerr:brk_cnt", 32'(ev_count), 32'd0);
        send(8'h1C);
        check("lerr:back_idle", 32'(ev_data), 32'h01C);
        cyc(1, 8'h2A, 0, 1);
        check("sync:cnt", 32'(ev_count), 32'd0);
        check("sync:err", 32'(err), 32'd0);

        phase = "async_rst";
        send(8'h16); send(8'hE0);
        #3 nrst = 0;
        #1;
        check("arst:count", 32'(ev_count), 32'd0);
        check("arst:valid", 32'(ev_valid), 32'd0);
        model_clear();
        #2 nrst = 1;

        phase = "random";
        for (int n = 0; n < 4000; n++) begin
            rd_pct = (n < 2000) ? 20 : 50;
            case ($urandom_range(0, 11))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                default: b = byte'($urandom_range(1, 254));
            endcase
            if ($urandom_range(0, 299) == 0) wait_idle(TMO - 1 + $urandom_range(0, 2));
            cyc($urandom_range(0, 99) < 55, b, $urandom_range(0, 99) < rd_pct,
                $urandom_range(0, 499) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
